udp_tx_arb: RTL and testbench

Two-requester scheduler and data feeder for the UDP/Ethernet transmit framer. It arbitrates between two frame sources, such as the CPU MMIO TX buffer and an internal reply engine, with round-robin fairness. It latches the winning descriptor and pulses the framer's start input. It serves the framer's per-word `tx_request` strobes from a shared synchronous word buffer through a one-word prefetch register, and enforces an inter-frame gap before the next grant.

---
 rtl/udp_tx_arb.sv | 179 +++++++++++++++++
 tb/tb_udp_tx_arb.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_arb.sv
// rtl/udp_tx_arb.sv - two-source round-robin TX scheduler and word feeder for the UDP framer
// Define UDP_TX_WATCHDOG_EN to abort a frame whose framer stalls for WDOG_CYCLES in BUSY.
module udp_tx_arb #(
  parameter int ADDR_W      = 9,
  parameter int IFG_CYCLES  = 12
`ifdef UDP_TX_WATCHDOG_EN
  , parameter int WDOG_CYCLES = 65535
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [15:0]       byte_num0,
  input  logic [15:0]       byte_num1,
  input  logic [31:0]       dest_ip0,
  input  logic [31:0]       dest_ip1,
  input  logic [47:0]       dest_mac0,
  input  logic [47:0]       dest_mac1,
  input  logic [15:0]       src_port0,
  input  logic [15:0]       src_port1,
  input  logic [15:0]       dest_port0,
  input  logic [15:0]       dest_port1,
  output logic [1:0]        done,
  output logic [1:0]        err,
  output logic              busy,
  output logic              buf_rd_en,
  output logic              buf_rd_sel,
  output logic [ADDR_W-1:0] buf_rd_addr,
  input  logic [31:0]       buf_rd_data,
  output logic              tx_start_en,
  output logic [31:0]       tx_data,
  output logic [15:0]       tx_byte_num,
  output logic [47:0]       dest_mac,
  output logic [31:0]       dest_ip,
  output logic [15:0]       src_port,
  output logic [15:0]       dest_port,
  input  logic              tx_request,
  input  logic              tx_done
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_BUSY, S_GAP} state_t;

  state_t      state, state_nxt;
  logic        last;
  logic [16:0] words, issued, req_words;
  logic [31:0] prefetch, gap_cnt;
  logic        cap;
  logic        win, grant, bad_len, wdog_fire;
  logic [15:0] sel_bytes;
  logic        load_desc, reject, rd_next, start_pulse, take_word, finish, finish_err;

  // Source 0 wins the first contested grant because last resets to 1.
  always_comb begin
    win       = (req == 2'b11) ? ~last : req[1];
    grant     = (state == S_IDLE) && (req != 2'b00);
    sel_bytes = win ? byte_num1 : byte_num0;
    req_words = ({1'b0, sel_bytes} + 17'd3) >> 2;
    bad_len   = (sel_bytes == 16'd0) || (req_words > (17'd1 << ADDR_W));
  end

`ifdef UDP_TX_WATCHDOG_EN
  logic [31:0] wdog_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              wdog_cnt <= '0;
    else if (state != S_BUSY || tx_request)  wdog_cnt <= '0;
    else                                     wdog_cnt <= wdog_cnt + 32'd1;
  end

  assign wdog_fire = (state == S_BUSY) && !tx_done && !tx_request &&
                     (wdog_cnt == 32'(WDOG_CYCLES - 1));
`else
  assign wdog_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant) state_nxt = bad_len ? S_GAP : S_FETCH;
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_BUSY;
      S_BUSY:  if (tx_done || wdog_fire) state_nxt = S_GAP;
      S_GAP:   if (gap_cnt == 32'd0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    load_desc   = 1'b0;
    reject      = 1'b0;
    rd_next     = 1'b0;
    start_pulse = 1'b0;
    take_word   = 1'b0;
    finish      = 1'b0;
    finish_err  = 1'b0;
    case (state)
      S_IDLE: begin
        load_desc = grant && !bad_len;
        reject    = grant && bad_len;
      end
      S_WAIT: start_pulse = 1'b1;
      S_BUSY: begin
        take_word  = tx_request;
        rd_next    = tx_request && (issued < words);
        finish     = tx_done || wdog_fire;
        finish_err = wdog_fire;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last        <= 1'b1;
      words       <= '0;
      issued      <= '0;
      prefetch    <= '0;
      gap_cnt     <= '0;
      cap         <= 1'b0;
      done        <= '0;
      err         <= '0;
      busy        <= 1'b0;
      buf_rd_en   <= 1'b0;
      buf_rd_sel  <= 1'b0;
      buf_rd_addr <= '0;
      tx_start_en <= 1'b0;
      tx_data     <= '0;
      tx_byte_num <= '0;
      dest_mac    <= '0;
      dest_ip     <= '0;
      src_port    <= '0;
      dest_port   <= '0;
    end else begin
      done        <= '0;
      err         <= '0;
      busy        <= (state_nxt != S_IDLE);
      tx_start_en <= start_pulse;
      buf_rd_en   <= load_desc | rd_next;
      // Read data lands one cycle after the strobe is sampled, so capture trails it by two edges.
      cap         <= buf_rd_en && (state == S_BUSY);
      if (load_desc || reject) begin
        buf_rd_sel <= win;
        last       <= win;
      end
      if (load_desc) begin
        words       <= req_words;
        issued      <= 17'd1;
        buf_rd_addr <= '0;
        tx_byte_num <= sel_bytes;
        dest_ip     <= win ? dest_ip1   : dest_ip0;
        dest_mac    <= win ? dest_mac1  : dest_mac0;
        src_port    <= win ? src_port1  : src_port0;
        dest_port   <= win ? dest_port1 : dest_port0;
      end
      if (reject) begin
        done[win] <= 1'b1;
        err[win]  <= 1'b1;
      end
      if (rd_next) begin
        buf_rd_addr <= issued[ADDR_W-1:0];
        issued      <= issued + 17'd1;
      end
      if (state == S_WAIT || cap) prefetch <= buf_rd_data;
      if (take_word) tx_data <= prefetch;
      if (finish) begin
        done[buf_rd_sel] <= 1'b1;
        err[buf_rd_sel]  <= finish_err;
      end
      if (reject || finish)                      gap_cnt <= 32'(IFG_CYCLES);
      else if (state == S_GAP && gap_cnt != 0)   gap_cnt <= gap_cnt - 32'd1;
    end
  end

endmodule

// File: tb/tb_udp_tx_arb.sv
// tb/tb_udp_tx_arb.sv - self-checking bench for udp_tx_arb
// Covers UDP_TX_WATCHDOG_EN when the macro is defined.
module tb_udp_tx_arb;
  localparam int ADDR_W = 9;
  localparam int IFG    = 12;
`ifdef UDP_TX_WATCHDOG_EN
  localparam int WDOG   = 100;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        req = 2'b00;
  logic [15:0]       byte_num0 = '0, byte_num1 = '0;
  logic [31:0]       dest_ip0 = '0, dest_ip1 = '0;
  logic [47:0]       dest_mac0 = '0, dest_mac1 = '0;
  logic [15:0]       src_port0 = '0, src_port1 = '0, dest_port0 = '0, dest_port1 = '0;
  logic [1:0]        done, err;
  logic              busy, buf_rd_en, buf_rd_sel;
  logic [ADDR_W-1:0] buf_rd_addr;
  logic [31:0]       buf_rd_data = '0;
  logic              tx_start_en;
  logic [31:0]       tx_data;
  logic [15:0]       tx_byte_num;
  logic [47:0]       dest_mac;
  logic [31:0]       dest_ip;
  logic [15:0]       src_port, dest_port;
  logic              tx_request = 1'b0, tx_done = 1'b0;

  always #5 clk = ~clk;

  udp_tx_arb #(
    .ADDR_W(ADDR_W), .IFG_CYCLES(IFG)
`ifdef UDP_TX_WATCHDOG_EN
    , .WDOG_CYCLES(WDOG)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .byte_num0(byte_num0), .byte_num1(byte_num1),
    .dest_ip0(dest_ip0), .dest_ip1(dest_ip1),
    .dest_mac0(dest_mac0), .dest_mac1(dest_mac1),
    .src_port0(src_port0), .src_port1(src_port1),
    .dest_port0(dest_port0), .dest_port1(dest_port1),
    .done(done), .err(err), .busy(busy),
    .buf_rd_en(buf_rd_en), .buf_rd_sel(buf_rd_sel), .buf_rd_addr(buf_rd_addr),
    .buf_rd_data(buf_rd_data), .tx_start_en(tx_start_en), .tx_data(tx_data),
    .tx_byte_num(tx_byte_num), .dest_mac(dest_mac), .dest_ip(dest_ip),
    .src_port(src_port), .dest_port(dest_port),
    .tx_request(tx_request), .tx_done(tx_done)
  );

  logic [31:0] mem0 [512];
  logic [31:0] mem1 [512];
  always @(posedge clk) if (buf_rd_en) buf_rd_data <= buf_rd_sel ? mem1[buf_rd_addr] : mem0[buf_rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          kind;   // 0 = start, 1 = done
    bit          owner;
    bit          e;
    logic [15:0] bytes;
    logic [31:0] ip;
    logic [47:0] mac;
    logic [15:0] sp, dp;
  } ev_t;

  ev_t exp_q[$];
  ev_t ev;
  int  n_vec = 0, n_err = 0, rd_total = 0, rd_last = 0, n_start = 0;
  bit  m_last = 1'b1, m_owner = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ev_t mk(input bit kind, input bit owner, input bit e);
    ev_t v;
    v.kind = kind; v.owner = owner; v.e = e;
    v.bytes = owner ? byte_num1  : byte_num0;
    v.ip    = owner ? dest_ip1   : dest_ip0;
    v.mac   = owner ? dest_mac1  : dest_mac0;
    v.sp    = owner ? src_port1  : src_port0;
    v.dp    = owner ? dest_port1 : dest_port0;
    return v;
  endfunction

  function automatic int n_words(input int b);
    return (b + 3) / 4;
  endfunction

  function automatic bit pick(input logic [1:0] r);
    return (r == 2'b11) ? ~m_last : r[1];
  endfunction

  // Compare process: event-ordered scoreboard plus per-cycle invariants.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("err_only_with_done", 64'(err & ~done), 0);
      if (buf_rd_en) begin
        rd_total++;
        rd_last = int'(buf_rd_addr);
        chk("rd_sel", buf_rd_sel, m_owner);
      end
      if (tx_start_en) begin
        n_start++;
        if (exp_q.size() == 0 || exp_q[0].kind) chk("unexpected_start", tx_start_en, 0);
        else begin
          ev = exp_q.pop_front();
          chk("hdr_bytes", tx_byte_num, ev.bytes);
          chk("hdr_ip", dest_ip, ev.ip);
          chk("hdr_mac", dest_mac, ev.mac);
          chk("hdr_ports", {src_port, dest_port}, {ev.sp, ev.dp});
        end
      end
      if (done != 2'b00) begin
        if (exp_q.size() == 0 || !exp_q[0].kind) chk("unexpected_done", done, 0);
        else begin
          ev = exp_q.pop_front();
          chk("done_owner", done, 2'b01 << ev.owner);
          chk("err_flag", err, ev.e ? (2'b01 << ev.owner) : 2'b00);
        end
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    chk("idle_reached", busy, 0);
  endtask

  task automatic wait_start(output int at);
    at = -1;
    for (int i = 0; i < 60 && at < 0; i++) begin
      @(negedge clk);
      if (tx_start_en) at = cyc;
    end
    chk("start_seen", at >= 0, 1);
  endtask

  task automatic serve(input bit o, input int b);
    for (int k = 0; k < n_words(b); k++) begin
      @(negedge clk) tx_request = 1'b1;
      @(negedge clk) tx_request = 1'b0;
      chk("tx_data", tx_data, o ? mem1[k] : mem0[k]);
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic finish_frame(input bit o, output int d);
    @(negedge clk);
    exp_q.push_back(mk(1'b1, o, 1'b0));
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    d = cyc;
    chk("done_after_tx_done", done, 2'b01 << o);
    chk("err_clean", err, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {done, err, busy, buf_rd_en, buf_rd_sel, buf_rd_addr, tx_start_en}, 0);
    chk({tag, "_data"}, tx_data, 0);
    chk({tag, "_bytes"}, tx_byte_num, 0);
    chk({tag, "_ip"}, dest_ip, 0);
    chk({tag, "_mac"}, dest_mac, 0);
    chk({tag, "_ports"}, {src_port, dest_port}, 0);
  endtask

  task automatic run_basic();
    int c0, at, rd0, d;
    wait_idle();
    byte_num0 = 16'd10; dest_ip0 = 32'hC0A8_0102; dest_mac0 = 48'h0200_0000_0001;
    src_port0 = 16'd5000; dest_port0 = 16'd6000;
    m_owner = 1'b0; m_last = pick(2'b01);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0));
    rd0 = rd_total;
    @(negedge clk); req = 2'b01; c0 = cyc;
    @(negedge clk);
    chk("rd_en_after_E0", buf_rd_en, 1);
    chk("rd_addr_first", buf_rd_addr, 0);
    chk("busy_after_E0", busy, 1);
    wait_start(at);
    chk("start_latency", at - c0, 3);
    dest_ip0 = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("start_one_cycle", tx_start_en, 0);
    serve(1'b0, 10);
    finish_frame(1'b0, d);
    req = 2'b00;
    chk("reads_10B", rd_total - rd0, 3);
    chk("last_addr_10B", rd_last, 2);
    chk("desc_held", dest_ip, 32'hC0A8_0102);
    dest_ip0 = 32'hC0A8_0102;
  endtask

  task automatic run_reject(input bit o, input int b);
    int busy_n, rd0, st0;
    wait_idle();
    if (o) byte_num1 = 16'(b); else byte_num0 = 16'(b);
    m_owner = o; m_last = o;
    exp_q.push_back(mk(1'b1, o, 1'b1));
    rd0 = rd_total; st0 = n_start; busy_n = 0;
    @(negedge clk); req = o ? 2'b10 : 2'b01;
    @(negedge clk);
    chk("rej_done", done, 2'b01 << o);
    chk("rej_err", err, 2'b01 << o);
    req = 2'b00;
    for (int i = 0; i < 40 && busy; i++) begin
      busy_n++;
      @(negedge clk);
    end
    chk("rej_busy_cycles", busy_n, IFG + 1);
    chk("rej_no_read", rd_total - rd0, 0);
    chk("rej_no_start", n_start - st0, 0);
  endtask

  task automatic run_long();
    int at, rd0, d;
    wait_idle();
    byte_num0 = 16'd2048;
    m_owner = 1'b0; m_last = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0));
    rd0 = rd_total;
    @(negedge clk); req = 2'b01;
    wait_start(at);
    serve(1'b0, 2048);
    finish_frame(1'b0, d);
    req = 2'b00;
    chk("reads_2048B", rd_total - rd0, 512);
    chk("last_addr_2048B", rd_last, 511);
  endtask

  task automatic run_reset();
    int at;
    wait_idle();
    byte_num0 = 16'd10;
    m_owner = 1'b0; m_last = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0));
    @(negedge clk); req = 2'b01;
    wait_start(at);
    @(negedge clk) tx_request = 1'b1;
    @(negedge clk) tx_request = 1'b0;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_data", tx_data, 32'hA1A2_A3A4);
    #2 rst_n = 1'b0;
    #1 chk_zero("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    req = 2'b00;
    m_last = 1'b1;
    run_basic();
  endtask

  task automatic run_alternate();
    int at, d;
    bit o;
    wait_idle();
    byte_num0 = 16'd8; byte_num1 = 16'd6;
    dest_ip1 = 32'h0A00_0005; dest_mac1 = '0; src_port1 = 16'd7000; dest_port1 = 16'd53;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    m_last = 1'b1;
    d = 0;
    for (int f = 0; f < 4; f++) begin
      o = pick(2'b11); m_last = o; m_owner = o;
      exp_q.push_back(mk(1'b0, o, 1'b0));
      if (f == 0) begin
        @(negedge clk); req = 2'b11;
      end
      wait_start(at);
      chk("rr_bytes", tx_byte_num, (f % 2) ? 6 : 8);
      if (f > 0) chk("ifg_spacing", at - d, IFG + 4);
      serve(o, o ? 6 : 8);
      finish_frame(o, d);
      if (f == 2) req[0] = 1'b0;
      if (f == 3) req = 2'b00;
    end
  endtask

`ifdef UDP_TX_WATCHDOG_EN
  task automatic run_wdog();
    int at, t;
    wait_idle();
    byte_num0 = 16'd10;
    m_owner = 1'b0; m_last = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1));
    @(negedge clk); req = 2'b01;
    wait_start(at);
    t = -1;
    for (int i = 0; i < 300 && t < 0; i++) begin
      @(negedge clk);
      if (done != 2'b00) t = cyc;
    end
    chk("wdog_delay", t - at, WDOG);
    chk("wdog_err", err, 2'b01);
    req = 2'b00;
    run_basic();
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 512; k++) begin
      mem0[k] = 32'h1000_0000 + k * 32'h0001_0203;
      mem1[k] = 32'hF000_0000 ^ k;
    end
    mem0[0] = 32'hA1A2_A3A4;
    mem0[1] = 32'hB1B2_B3B4;
    mem0[2] = 32'hC1C2_C3C4;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    run_basic();
    run_reject(1'b1, 0);
    run_reject(1'b0, 2049);
    run_long();
    run_reset();
    run_alternate();
`ifdef UDP_TX_WATCHDOG_EN
    run_wdog();
`endif
    repeat (20) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
